bridge_deadtime: RTL and testbench

- Downstream stage of the command-bus controller.
- Takes the controller's requested bridge switch pattern (TOP1-4 / BOT1-4) and drives the physical gate outputs.
- Guarantees break-before-make dead time, a minimum on-time, and shoot-through rejection.
- Forces all switches off on fault.
- Sits between the controller's o_top/o_bot registers and the O_TOP_x/O_BOT_x pins.

---
 rtl/bridge_deadtime_pkg.sv | 27 ++
 rtl/bridge_deadtime.sv | 124 ++++++++++++
 tb/tb_bridge_deadtime.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bridge_deadtime_pkg.sv
// Shared definitions for the H-bridge gate-drive stage: FSM states and the
// named switch patterns that the command-bus controller also uses.
package bridge_deadtime_pkg;

  typedef enum logic [1:0] {
    BR_OFF   = 2'd0,
    BR_DEAD  = 2'd1,
    BR_ON    = 2'd2,
    BR_FAULT = 2'd3
  } bridge_state_t;

  // Packed so that {top, bot} is the 8-bit pattern used throughout.
  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
  } pattern_t;

  localparam pattern_t PAT_PLUS    = '{top: 4'b0001, bot: 4'b0010};
  localparam pattern_t PAT_MINUS   = '{top: 4'b0010, bot: 4'b0001};
  localparam pattern_t PAT_PAUSE_P = '{top: 4'b0100, bot: 4'b1000};
  localparam pattern_t PAT_PAUSE_N = '{top: 4'b1000, bot: 4'b0100};

  function automatic logic is_shoot_through(input logic [3:0] t, input logic [3:0] b);
    return |(t & b);
  endfunction

endpackage

// File: rtl/bridge_deadtime.sv
// Gate-drive stage: break-before-make dead time, minimum on-time,
// shoot-through rejection and fault shutdown between controller and pins.
module bridge_deadtime
  import bridge_deadtime_pkg::*;
#(
  parameter int DEADTIME_CYC = 100,
  parameter int MIN_ON_CYC   = 500,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       fault,
  input  logic [3:0] req_top,
  input  logic [3:0] req_bot,
  output logic [3:0] top,
  output logic [3:0] bot,
  output logic       busy,
  output logic       active,
  output logic       illegal
);

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Whole FSM context in one struct so a checker can bind to r_q directly.
  typedef struct packed {
    bridge_state_t    state;
    logic [7:0]       tgt;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] ocnt;
    logic             illegal;
  } regs_t;

  regs_t      r_q;
  regs_t      w_d;
  logic       w_shoot;
  logic [7:0] w_eff;
  logic [3:0] r_top, r_bot;
  logic       r_busy, r_active;

  assign w_shoot = is_shoot_through(req_top, req_bot);
  assign w_eff   = w_shoot ? 8'h00 : {req_top, req_bot};

  always_comb begin
    w_d = r_q;
    if (w_shoot) w_d.illegal = 1'b1;
    if (fault) begin
      w_d.state = BR_FAULT;
      w_d.tgt   = 8'h00;
      w_d.dcnt  = '0;
      w_d.ocnt  = '0;
    end else begin
      case (r_q.state)
        BR_OFF: begin
          if (w_eff != 8'h00) begin
            w_d.state = BR_DEAD;
            w_d.tgt   = w_eff;
            w_d.dcnt  = DEAD_LOAD;
          end
        end
        BR_DEAD: begin
          if (w_eff == 8'h00) begin
            w_d.state = BR_OFF;
            w_d.tgt   = 8'h00;
            w_d.dcnt  = '0;
          end else if (w_eff != r_q.tgt) begin
            w_d.tgt  = w_eff;
            w_d.dcnt = DEAD_LOAD;
          end else if (r_q.dcnt == '0) begin
            w_d.state = BR_ON;
            w_d.ocnt  = ON_LOAD;
          end else begin
            w_d.dcnt = r_q.dcnt - CNT_ONE;
          end
        end
        BR_ON: begin
          // Turn-off is never held back by the minimum on-time.
          if (w_eff == 8'h00) begin
            w_d.state = BR_OFF;
            w_d.tgt   = 8'h00;
            w_d.ocnt  = '0;
          end else if (w_eff != r_q.tgt && r_q.ocnt == '0) begin
            w_d.state = BR_DEAD;
            w_d.tgt   = w_eff;
            w_d.dcnt  = DEAD_LOAD;
          end else if (r_q.ocnt != '0) begin
            w_d.ocnt = r_q.ocnt - CNT_ONE;
          end
        end
        BR_FAULT: begin
          if (w_eff == 8'h00) w_d.state = BR_OFF;
        end
        default: begin
          w_d.state = BR_OFF;
          w_d.tgt   = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q      <= '{state: BR_OFF, tgt: 8'h00, dcnt: '0, ocnt: '0, illegal: 1'b0};
      r_top    <= 4'h0;
      r_bot    <= 4'h0;
      r_busy   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_q      <= w_d;
      r_top    <= (w_d.state == BR_ON) ? w_d.tgt[7:4] : 4'h0;
      r_bot    <= (w_d.state == BR_ON) ? w_d.tgt[3:0] : 4'h0;
      r_busy   <= (w_d.state == BR_DEAD);
      r_active <= (w_d.state == BR_ON);
    end
  end

  assign top     = r_top;
  assign bot     = r_bot;
  assign busy    = r_busy;
  assign active  = r_active;
  assign illegal = r_q.illegal;

endmodule

// File: tb/tb_bridge_deadtime.sv
// Bench for bridge_deadtime: directed scenarios plus random requests, every
// cycle compared against a behavioural model through an expected-value queue.
module tb_bridge_deadtime;
  import bridge_deadtime_pkg::*;

  localparam int D = 100;
  localparam int M = 500;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       fault = 1'b0;
  logic [3:0] req_top = 4'h0;
  logic [3:0] req_bot = 4'h0;
  logic [3:0] top, bot;
  logic       busy, active, illegal;

  always #5 clk = ~clk;

  bridge_deadtime #(.DEADTIME_CYC(D), .MIN_ON_CYC(M), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .fault(fault),
    .req_top(req_top), .req_bot(req_bot),
    .top(top), .bot(bot), .busy(busy), .active(active), .illegal(illegal)
  );

  // Expected word: {top, bot, busy, active, illegal}
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model: what is on the pins, what is waiting behind a dead gap, how long
  // each has been so, and whether a fault lockout is in force.
  logic [7:0] m_out = 8'h00;
  logic [7:0] m_pend = 8'h00;
  int         m_zero_cycles = 0;
  int         m_shown_cycles = 0;
  bit         m_faulted = 1'b0;
  bit         m_illegal = 1'b0;

  function automatic void model_edge(input logic rn, input logic f, input logic [7:0] req);
    logic [7:0] eff;
    if (!rn) begin
      m_out = 8'h00; m_pend = 8'h00; m_faulted = 1'b0; m_illegal = 1'b0;
      m_zero_cycles = 0; m_shown_cycles = 0;
      return;
    end
    eff = ((req[7:4] & req[3:0]) != 4'h0) ? 8'h00 : req;
    if ((req[7:4] & req[3:0]) != 4'h0) m_illegal = 1'b1;
    if (f) begin
      m_faulted = 1'b1; m_out = 8'h00; m_pend = 8'h00;
    end else if (m_faulted) begin
      if (eff == 8'h00) m_faulted = 1'b0;
    end else if (m_out != 8'h00) begin
      m_shown_cycles++;
      if (eff == 8'h00) begin
        m_out = 8'h00;
      end else if (eff != m_out && m_shown_cycles >= M) begin
        m_out = 8'h00; m_pend = eff; m_zero_cycles = 0;
      end
    end else if (m_pend != 8'h00) begin
      if (eff == 8'h00) begin
        m_pend = 8'h00;
      end else if (eff != m_pend) begin
        m_pend = eff; m_zero_cycles = 0;
      end else begin
        m_zero_cycles++;
        if (m_zero_cycles >= D) begin
          m_out = m_pend; m_pend = 8'h00; m_shown_cycles = 0;
        end
      end
    end else if (eff != 8'h00) begin
      m_pend = eff; m_zero_cycles = 0;
    end
  endfunction

  task automatic step(input logic rn, input logic f, input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      rstn = rn; fault = f; req_top = pat[7:4]; req_bot = pat[3:0];
      @(posedge clk);
      model_edge(rn, f, pat);
      exp_q.push_back({m_out, (m_pend != 8'h00 && m_out == 8'h00), (m_out != 8'h00), m_illegal});
      #1;
    end
  endtask

  // Monitor: one output word per clock, sampled on the falling edge.
  logic [7:0] prev_out = 8'h00;
  always @(negedge clk) begin
    logic [10:0] got, exp_w;
    logic [7:0]  cur;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      got   = {top, bot, busy, active, illegal};
      cur   = {top, bot};
      n_checks++;
      if (got !== exp_w) begin
        n_fail++;
        $display("FAIL outputs t=%0t got top=%b bot=%b busy=%b active=%b illegal=%b exp top=%b bot=%b busy=%b active=%b illegal=%b",
                 $time, got[10:7], got[6:3], got[2], got[1], got[0],
                 exp_w[10:7], exp_w[6:3], exp_w[2], exp_w[1], exp_w[0]);
      end
      n_checks++;
      if ((top & bot) != 4'h0) begin
        n_fail++;
        $display("FAIL shoot_through t=%0t got top=%b bot=%b exp disjoint", $time, top, bot);
      end
      n_checks++;
      if (prev_out != 8'h00 && cur != 8'h00 && cur != prev_out) begin
        n_fail++;
        $display("FAIL direct_switch t=%0t got %b -> %b exp zero gap", $time, prev_out, cur);
      end
      prev_out = cur;
    end
  end

  initial begin
    logic [7:0] pats[5];
    logic [7:0] p;
    pats[0] = PAT_PLUS; pats[1] = PAT_MINUS; pats[2] = PAT_PAUSE_P;
    pats[3] = PAT_PAUSE_N; pats[4] = 8'h00;

    step(1'b0, 1'b0, 8'h00, 3);
    // Turn-on latency and a long-held switch to the opposite polarity
    step(1'b1, 1'b0, 8'h00, 7);
    step(1'b1, 1'b0, PAT_PLUS, 700);
    step(1'b1, 1'b0, PAT_MINUS, 700);
    // Early change request held off by the minimum on-time
    step(1'b1, 1'b0, 8'h00, 5);
    step(1'b1, 1'b0, PAT_PLUS, 110);
    step(1'b1, 1'b0, PAT_MINUS, 700);
    // Shoot-through request, then a legal one
    step(1'b1, 1'b0, 8'h00, 5);
    step(1'b1, 1'b0, 8'b0001_0001, 3);
    step(1'b1, 1'b0, PAT_PLUS, 150);
    // Fault pulse while active
    step(1'b1, 1'b0, 8'h00, 3);
    step(1'b1, 1'b0, PAT_PAUSE_P, 150);
    step(1'b1, 1'b1, PAT_PAUSE_P, 1);
    step(1'b1, 1'b0, PAT_PAUSE_P, 5);
    step(1'b1, 1'b0, 8'h00, 3);
    step(1'b1, 1'b0, PAT_PAUSE_P, 150);
    // Retarget mid-dead-time, then reset mid-dead-time
    step(1'b1, 1'b0, 8'h00, 3);
    step(1'b1, 1'b0, PAT_PLUS, 50);
    step(1'b1, 1'b0, PAT_PAUSE_N, 150);
    step(1'b1, 1'b0, 8'b0010_0010, 2);
    step(1'b1, 1'b0, PAT_PLUS, 50);
    step(1'b0, 1'b0, PAT_PLUS, 1);
    step(1'b1, 1'b0, 8'h00, 5);
    // Random segments
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 5) == 0) p = 8'($urandom_range(0, 255));
      else p = pats[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) step(1'b1, 1'b1, p, $urandom_range(1, 3));
      step(1'b1, 1'b0, p, $urandom_range(1, 650));
    end
    step(1'b1, 1'b0, 8'h00, 3);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d entries left exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
